// File: rtl/alu_pkg.sv
// Purpose : shared ALU operation codes, RV32I opcodes and the decoded-entry struct.
// Latency : n/a (types, constants and one pure helper function).
// Backpressure: n/a.
// Used by the ALU and by alu_ctrl_decoder so both sides agree on the encodings.
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_AND     = 4'b0010;
    localparam logic [3:0] ALU_OR      = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SLL     = 4'b0101;
    localparam logic [3:0] ALU_SRL     = 4'b0110;
    localparam logic [3:0] ALU_SRA_REG = 4'b0111;
    localparam logic [3:0] ALU_SRA_IMM = 4'b1000;
    localparam logic [3:0] ALU_SLT     = 4'b1001;
    localparam logic [3:0] ALU_SLTU    = 4'b1010;
    localparam logic [3:0] ALU_PASS    = 4'b1011;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src_imm;
        logic       reg_write;
        logic       illegal;
    } dec_t;

    localparam dec_t DEC_ILLEGAL = '{alu_ctrl: ALU_ADD, alu_src_imm: 1'b0,
                                     reg_write: 1'b0, illegal: 1'b1};

    // funct3 -> operation shared by OP and OP-IMM; the funct7 variants
    // (SUB, SRA) are resolved by the caller.
    function automatic logic [3:0] base_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_lut.sv
// Purpose : combinational RV32I instruction -> ALU control decode.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; no handshake at this level.
// Ports: instr (instruction word in), dec (decoded entry out).
module alu_ctrl_lut
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output dec_t                  dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec = DEC_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                dec = '{alu_ctrl: base_op(funct3), alu_src_imm: 1'b0,
                        reg_write: 1'b1, illegal: 1'b0};
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec.alu_ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec.alu_ctrl = ALU_SRA_REG;
                end else if (funct7 != F7_BASE) begin
                    dec = DEC_ILLEGAL;
                end
            end
            OP_ITYPE: begin
                dec = '{alu_ctrl: base_op(funct3), alu_src_imm: 1'b1,
                        reg_write: 1'b1, illegal: 1'b0};
                // Upper immediate bits are only an opcode extension for shifts.
                if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                    dec.alu_ctrl = ALU_SRA_IMM;
                end else if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 != F7_BASE) begin
                    dec = DEC_ILLEGAL;
                end
            end
            OP_LUI: begin
                dec = '{alu_ctrl: ALU_PASS, alu_src_imm: 1'b1, reg_write: 1'b1, illegal: 1'b0};
            end
            OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD: begin
                dec = '{alu_ctrl: ALU_ADD, alu_src_imm: 1'b1, reg_write: 1'b1, illegal: 1'b0};
            end
            OP_STORE: begin
                dec = '{alu_ctrl: ALU_ADD, alu_src_imm: 1'b1, reg_write: 1'b0, illegal: 1'b0};
            end
            OP_BRANCH: begin
                dec = '{alu_ctrl: ALU_SUB, alu_src_imm: 1'b0, reg_write: 1'b0, illegal: 1'b0};
                case (funct3)
                    3'b000, 3'b001: dec.alu_ctrl = ALU_SUB;
                    3'b100, 3'b101: dec.alu_ctrl = ALU_SLT;
                    3'b110, 3'b111: dec.alu_ctrl = ALU_SLTU;
                    default:        dec = DEC_ILLEGAL;
                endcase
            end
            default: dec = DEC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Purpose : registered ALU-control decode stage with valid/ready handshake and sticky illegal flag.
// Latency : 1 cycle from accept to out_valid.
// Backpressure: default build holds one entry, in_ready = !out_valid || out_ready;
//               with DECODE_SKID_EN a 2-entry skid buffer gives a registered in_ready.
// Ports: clk, rst (sync active-high), flush; in_valid/in_ready/instr upstream;
//        out_valid/out_ready, ALUctrl, alu_src_imm, reg_write, illegal downstream;
//        illegal_seen sticky until rst.
module alu_ctrl_decoder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            ALUctrl,
    output logic                  alu_src_imm,
    output logic                  reg_write,
    output logic                  illegal,
    output logic                  illegal_seen
);

    dec_t dec_in;
    dec_t head_q;
    logic head_vld;
    logic accept;
    logic leave;

    alu_ctrl_lut #(.DATA_WIDTH(DATA_WIDTH)) u_lut (
        .instr (instr),
        .dec   (dec_in)
    );

    assign accept = in_valid && in_ready;
    assign leave  = head_vld && out_ready;

`ifdef DECODE_SKID_EN
    dec_t skid_q;
    logic skid_vld;
    logic rdy_q;
    logic full_nxt;

    // Full next cycle when the skid entry stays, or it is about to be filled.
    assign full_nxt = head_vld && (skid_vld ? !leave : (accept && !leave));
    assign in_ready = rdy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            head_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else if (flush) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            rdy_q <= !full_nxt;
            if (leave) begin
                // A valid skid entry implies full, so no accept can coincide.
                if (skid_vld) begin
                    head_q   <= skid_q;
                    skid_vld <= 1'b0;
                end else if (accept) begin
                    head_q <= dec_in;
                end else begin
                    head_vld <= 1'b0;
                end
            end else if (accept) begin
                if (!head_vld) begin
                    head_q   <= dec_in;
                    head_vld <= 1'b1;
                end else begin
                    skid_q   <= dec_in;
                    skid_vld <= 1'b1;
                end
            end
        end
    end
`else
    assign in_ready = !head_vld || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            head_vld <= 1'b0;
        end else if (flush) begin
            head_vld <= 1'b0;
        end else if (accept) begin
            head_q   <= dec_in;
            head_vld <= 1'b1;
        end else if (leave) begin
            head_vld <= 1'b0;
        end
    end
`endif

    // A flushed entry never leaves, so it cannot set the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen <= 1'b0;
        end else if (leave && !flush && head_q.illegal) begin
            illegal_seen <= 1'b1;
        end
    end

    assign out_valid   = head_vld;
    assign ALUctrl     = head_q.alu_ctrl;
    assign alu_src_imm = head_q.alu_src_imm;
    assign reg_write   = head_q.reg_write;
    assign illegal     = head_q.illegal;

endmodule
